// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-ported RAM data port between two bus masters:
// M0 (core data port) and M1 (DMA/debug loader). Round-robin arbitration
// with a same-cycle combinational grant, fixed 1-cycle read latency with the
// read data routed back to its issuer, and a bounded bus lock for atomic
// read-modify-write sequences.
//
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   mX_req_i / mX_lock_i        per-master request / keep-ownership request
//   mX_we_i, mX_addr_i,         per-master byte enables (0 = read), address,
//   mX_data_i                   write data
//   mX_gnt_o                    transfer accepted this cycle (combinational)
//   mX_rvalid_o, mX_data_o      read response, one cycle after accepted read
//   s_en_o, s_we_o, s_addr_o,   RAM port request side
//   s_data_o
//   s_data_i                    RAM read data, valid 1 cycle after a read
module mem_port_arbiter #(
    parameter int unsigned AW       = 16,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req_i,
    input  logic          m0_lock_i,
    input  logic [3:0]    m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [31:0]   m0_data_i,
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    output logic [31:0]   m0_data_o,
    input  logic          m1_req_i,
    input  logic          m1_lock_i,
    input  logic [3:0]    m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [31:0]   m1_data_i,
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    output logic [31:0]   m1_data_o,
    output logic          s_en_o,
    output logic [3:0]    s_we_o,
    output logic [AW-1:0] s_addr_o,
    output logic [31:0]   s_data_o,
    input  logic [31:0]   s_data_i
);

    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t        state_r, state_nx;
    logic          owner_r, owner_nx;     // 0 = M0, 1 = M1
    logic          last_r, last_nx;       // last granted master
    logic [CW-1:0] lock_cnt_r, lock_cnt_nx;
    logic          pend_r, pend_nx;
    logic          pend_id_r, pend_id_nx;

    logic          gnt0, gnt1, any_gnt, win_id, win_lock, owner_lock;
    logic [3:0]    win_we;

    // Grant decode; reset forces all grants low.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (state_r == S_LOCKED) begin
                gnt0 = m0_req_i & ~owner_r;
                gnt1 = m1_req_i & owner_r;
            end else if (m0_req_i && m1_req_i) begin
                // Tie goes to the master that did not win last.
                gnt0 = last_r;
                gnt1 = ~last_r;
            end else begin
                gnt0 = m0_req_i;
                gnt1 = m1_req_i;
            end
        end
    end

    assign any_gnt    = gnt0 | gnt1;
    assign win_id     = gnt1;
    assign win_lock   = gnt1 ? m1_lock_i : m0_lock_i;
    assign win_we     = gnt1 ? m1_we_i : m0_we_i;
    assign owner_lock = owner_r ? m1_lock_i : m0_lock_i;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            owner_r    <= 1'b0;
            last_r     <= 1'b1;
            lock_cnt_r <= '0;
            pend_r     <= 1'b0;
            pend_id_r  <= 1'b0;
        end else begin
            state_r    <= state_nx;
            owner_r    <= owner_nx;
            last_r     <= last_nx;
            lock_cnt_r <= lock_cnt_nx;
            pend_r     <= pend_nx;
            pend_id_r  <= pend_id_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx    = state_r;
        owner_nx    = owner_r;
        lock_cnt_nx = lock_cnt_r;
        last_nx     = any_gnt ? win_id : last_r;
        pend_nx     = any_gnt && (win_we == 4'b0000);
        pend_id_nx  = win_id;
        case (state_r)
            S_IDLE: begin
                if (any_gnt && win_lock) begin
                    state_nx    = S_LOCKED;
                    owner_nx    = win_id;
                    lock_cnt_nx = CW'(1);
                end
            end
            S_LOCKED: begin
                // Lock ends on request drop or when the hold budget is spent;
                // last_r already equals the owner, so a waiting peer wins next.
                if (!owner_lock || lock_cnt_r == CW'(LOCK_MAX)) begin
                    state_nx    = S_IDLE;
                    lock_cnt_nx = '0;
                end else begin
                    lock_cnt_nx = lock_cnt_r + CW'(1);
                end
            end
            default: begin
                state_nx    = S_IDLE;
                lock_cnt_nx = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        m0_gnt_o    = gnt0;
        m1_gnt_o    = gnt1;
        s_en_o      = any_gnt;
        s_we_o      = '0;
        s_addr_o    = '0;
        s_data_o    = '0;
        if (gnt1) begin
            s_we_o   = m1_we_i;
            s_addr_o = m1_addr_i;
            s_data_o = m1_data_i;
        end else if (gnt0) begin
            s_we_o   = m0_we_i;
            s_addr_o = m0_addr_i;
            s_data_o = m0_data_i;
        end
        m0_rvalid_o = ~reset & pend_r & ~pend_id_r;
        m1_rvalid_o = ~reset & pend_r & pend_id_r;
        m0_data_o   = m0_rvalid_o ? s_data_i : '0;
        m1_data_o   = m1_rvalid_o ? s_data_i : '0;
    end

endmodule
